// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared types and constants for the two-requester burst arbiter
package mux2_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic SEL_REQ0 = 1'b0;
    localparam logic SEL_REQ1 = 1'b1;

    function automatic logic [1:0] sel_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - combinational winner picker; MUX2_ARB_RR_EN selects round-robin tie-break
// over fixed priority (requester 0 wins ties, ptr ignored)
module arb_pick2
    import mux2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner
);

`ifdef MUX2_ARB_RR_EN
    // A lone requester wins outright; on a tie the pointer names the winner.
    always_comb begin
        winner = SEL_REQ0;
        if (req == 2'b11)
            winner = ptr;
        else if (req[1])
            winner = SEL_REQ1;
    end
`else
    logic ptr_unused;
    assign ptr_unused = ptr;

    always_comb begin
        winner = SEL_REQ0;
        if (req == 2'b10)
            winner = SEL_REQ1;
    end
`endif

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - burst-holding arbiter driving a shared 2:1 data mux
// MUX2_ARB_RR_EN enables the round-robin pointer; without it ties go to requester 0
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    last,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic          ready_in,
    output logic [1:0]    gnt,
    output logic          sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [1:0]    ack
);

    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

    arb_state_t    state;
    logic [CW-1:0] beat_cnt;
    logic          busy;
    logic          accept;
    logic          release_now;
    logic          pick_ptr;
    logic          winner;

`ifdef MUX2_ARB_RR_EN
    logic rr_ptr;
    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = SEL_REQ0;
`endif

    arb_pick2 u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner)
    );

    assign busy        = (state == BUSY);
    assign dout        = sel ? din1 : din0;
    assign dout_valid  = busy & req[sel];
    assign accept      = dout_valid & ready_in;
    assign release_now = accept & (last[sel] | (beat_cnt == LAST_BEAT));

    // ack follows the granted slot and ready_in, even while that requester idles mid-burst.
    always_comb begin
        ack = 2'b00;
        if (busy & ready_in)
            ack[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            sel      <= SEL_REQ0;
            beat_cnt <= '0;
`ifdef MUX2_ARB_RR_EN
            rr_ptr   <= SEL_REQ0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= sel_to_onehot(winner);
                        sel      <= winner;
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end else begin
                        gnt <= 2'b00;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
`ifdef MUX2_ARB_RR_EN
                        rr_ptr <= ~sel;
`endif
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule
